// File: rtl/udp_echo_pkg.sv
// -----------------------------------------------------------------------------
// udp_echo_pkg : shared state encoding and constants for the UDP echo responder
// rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package udp_echo_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RX     = 3'd1,
      DROP   = 3'd2,
      TX_HDR = 3'd3,
      TX_PAY = 3'd4
   } state_t;

   localparam int UDP_HDR_LEN = 8;

endpackage

`default_nettype wire

// File: rtl/udp_echo_if.sv
// -----------------------------------------------------------------------------
// udp_echo_if : one UDP header + AXI-stream payload channel of the stack
// rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface udp_echo_if;

   logic        hdr_valid;
   logic        hdr_ready;
   logic [5:0]  ip_dscp;
   logic [1:0]  ip_ecn;
   logic [7:0]  ip_ttl;
   logic [31:0] ip_source_ip;
   logic [31:0] ip_dest_ip;
   logic [15:0] source_port;
   logic [15:0] dest_port;
   logic [15:0] length;
   logic [15:0] checksum;
   logic [7:0]  tdata;
   logic        tvalid;
   logic        tready;
   logic        tlast;
   logic        tuser;

   modport master (
      output hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
             source_port, dest_port, length, checksum,
             tdata, tvalid, tlast, tuser,
      input  hdr_ready, tready
   );

   modport slave (
      input  hdr_valid, ip_dscp, ip_ecn, ip_ttl, ip_source_ip, ip_dest_ip,
             source_port, dest_port, length, checksum,
             tdata, tvalid, tlast, tuser,
      output hdr_ready, tready
   );

endinterface

`default_nettype wire

// File: rtl/udp_echo_buf.sv
// -----------------------------------------------------------------------------
// udp_echo_buf : simple dual-port byte RAM, 2**ADDR_WIDTH deep, registered read
// rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module udp_echo_buf #(
   parameter int ADDR_WIDTH = 11
) (
   input  wire logic                  clk,
   input  wire logic                  i_wr_en,
   input  wire logic [ADDR_WIDTH-1:0] i_wr_addr,
   input  wire logic [7:0]            i_wr_data,
   input  wire logic                  i_rd_en,
   input  wire logic [ADDR_WIDTH-1:0] i_rd_addr,
   output logic      [7:0]            o_rd_data
);

   logic [7:0] r_mem [2**ADDR_WIDTH];
   logic [7:0] r_rd_data;

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
   end

   assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/udp_echo_responder.sv
// -----------------------------------------------------------------------------
// udp_echo_responder : store-and-forward UDP echo on a listen port.
// Optional counters enabled by defining UDP_ECHO_STATS_EN.   rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module udp_echo_responder
   import udp_echo_pkg::*;
#(
   parameter int         BUF_ADDR_WIDTH = 11,
   parameter logic [7:0] IP_TTL         = 8'd64,
   parameter logic [5:0] IP_DSCP        = 6'd0
) (
   input  wire logic        clk,
   input  wire logic        rst,
   udp_echo_if.slave        s_udp,
   udp_echo_if.master       m_udp,
   input  wire logic [15:0] listen_port,
   output logic             busy
`ifdef UDP_ECHO_STATS_EN
   ,
   output logic [31:0]      stat_echo_count,
   output logic [31:0]      stat_drop_count
`endif
);

   localparam int c_ptr_w = BUF_ADDR_WIDTH + 1;
   localparam logic [c_ptr_w-1:0] c_depth = {1'b1, {BUF_ADDR_WIDTH{1'b0}}};

   state_t r_state, w_state_nxt;

   logic               r_hdr_ready;
   logic [31:0]        r_src_ip, r_dst_ip;
   logic [15:0]        r_src_port, r_dst_port, r_length;
   logic [7:0]         r_ttl;
   logic [5:0]         r_dscp;
   logic [c_ptr_w-1:0] r_wr_ptr, r_rd_ptr;
   logic               r_rd_pend, r_rd_last_pend;
   logic               r_tvalid, r_tlast, r_sk_valid, r_sk_last;
   logic [7:0]         r_tdata, r_sk_data;

   logic               w_hdr_hs, w_rx_ready, w_rx_beat, w_full;
   logic               w_wr_en, w_drop_evt, w_tx_pop, w_tx_done, w_issue;
   logic [1:0]         w_occ;
   logic [7:0]         w_rd_data;
   logic [15:0]        w_len;
   logic               w_unused_rx;

   assign w_hdr_hs   = (r_state == IDLE) && r_hdr_ready && s_udp.hdr_valid;
   assign w_rx_ready = (r_state == RX) || (r_state == DROP);
   assign w_rx_beat  = w_rx_ready && s_udp.tvalid;
   assign w_full     = (r_wr_ptr == c_depth);
   assign w_tx_pop   = r_tvalid && m_udp.tready;
   assign w_tx_done  = w_tx_pop && r_tlast;
   assign w_len      = 16'(r_wr_ptr) + 16'(UDP_HDR_LEN) + 16'd1;

   // Reads are only launched when the output register plus skid can absorb them
   assign w_occ   = 2'(r_tvalid) + 2'(r_sk_valid) + 2'(r_rd_pend);
   assign w_issue = (r_state == TX_PAY) && (r_rd_ptr != r_wr_ptr) &&
                    ((w_occ - 2'(w_tx_pop)) <= 2'd1);

   assign w_unused_rx = ^{s_udp.ip_dscp, s_udp.ip_ecn, s_udp.ip_ttl,
                          s_udp.length, s_udp.checksum};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;
      w_drop_evt  = 1'b0;
      case (r_state)
         IDLE: if (w_hdr_hs)
            w_state_nxt = (s_udp.dest_port == listen_port) ? RX : DROP;
         RX: if (w_rx_beat) begin
            if (w_full) begin
               w_drop_evt  = 1'b1;
               w_state_nxt = s_udp.tlast ? IDLE : DROP;
            end else begin
               w_wr_en = 1'b1;
               if (s_udp.tlast) begin
                  w_drop_evt  = s_udp.tuser;
                  w_state_nxt = s_udp.tuser ? IDLE : TX_HDR;
               end
            end
         end
         DROP:    if (w_rx_beat && s_udp.tlast) w_state_nxt = IDLE;
         TX_HDR:  if (m_udp.hdr_ready) w_state_nxt = TX_PAY;
         TX_PAY:  if (w_tx_done) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hdr_ready    <= 1'b0;
         r_src_ip       <= '0;
         r_dst_ip       <= '0;
         r_src_port     <= '0;
         r_dst_port     <= '0;
         r_length       <= '0;
         r_ttl          <= '0;
         r_dscp         <= '0;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_rd_pend      <= 1'b0;
         r_rd_last_pend <= 1'b0;
         r_tvalid       <= 1'b0;
         r_tdata        <= '0;
         r_tlast        <= 1'b0;
         r_sk_valid     <= 1'b0;
         r_sk_data      <= '0;
         r_sk_last      <= 1'b0;
      end else begin
         r_hdr_ready <= (w_state_nxt == IDLE);
         if (w_hdr_hs) begin
            r_src_ip   <= s_udp.ip_dest_ip;
            r_dst_ip   <= s_udp.ip_source_ip;
            r_src_port <= s_udp.dest_port;
            r_dst_port <= s_udp.source_port;
            r_ttl      <= IP_TTL;
            r_dscp     <= IP_DSCP;
         end
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (r_state == RX && w_state_nxt == TX_HDR) r_length <= w_len;

         r_rd_pend      <= w_issue;
         r_rd_last_pend <= w_issue && (r_rd_ptr == r_wr_ptr - 1'b1);
         if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;

         if (!r_tvalid || w_tx_pop) begin
            if (r_sk_valid) begin
               r_tdata    <= r_sk_data;
               r_tlast    <= r_sk_last;
               r_sk_valid <= r_rd_pend;
               r_sk_data  <= w_rd_data;
               r_sk_last  <= r_rd_last_pend;
            end else begin
               r_tvalid <= r_rd_pend;
               r_tdata  <= w_rd_data;
               r_tlast  <= r_rd_last_pend;
            end
         end else if (r_rd_pend) begin
            r_sk_valid <= 1'b1;
            r_sk_data  <= w_rd_data;
            r_sk_last  <= r_rd_last_pend;
         end

         // Every return to IDLE discards the buffer and any read pipeline contents
         if (w_state_nxt == IDLE) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_pend  <= 1'b0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_sk_valid <= 1'b0;
         end
      end
   end

   udp_echo_buf #(
      .ADDR_WIDTH (BUF_ADDR_WIDTH)
   ) u_buf (
      .clk       (clk),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (r_wr_ptr[BUF_ADDR_WIDTH-1:0]),
      .i_wr_data (s_udp.tdata),
      .i_rd_en   (w_issue),
      .i_rd_addr (r_rd_ptr[BUF_ADDR_WIDTH-1:0]),
      .o_rd_data (w_rd_data)
   );

   assign s_udp.hdr_ready    = r_hdr_ready;
   assign s_udp.tready       = w_rx_ready;
   assign m_udp.hdr_valid    = (r_state == TX_HDR);
   assign m_udp.ip_dscp      = r_dscp;
   assign m_udp.ip_ecn       = 2'd0;
   assign m_udp.ip_ttl       = r_ttl;
   assign m_udp.ip_source_ip = r_src_ip;
   assign m_udp.ip_dest_ip   = r_dst_ip;
   assign m_udp.source_port  = r_src_port;
   assign m_udp.dest_port    = r_dst_port;
   assign m_udp.length       = r_length;
   assign m_udp.checksum     = 16'd0;
   assign m_udp.tdata        = r_tdata;
   assign m_udp.tvalid       = r_tvalid;
   assign m_udp.tlast        = r_tlast;
   assign m_udp.tuser        = 1'b0;
   assign busy               = (r_state != IDLE);

`ifdef UDP_ECHO_STATS_EN
   logic [31:0] r_echo_cnt, r_drop_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_echo_cnt <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (w_tx_done)  r_echo_cnt <= r_echo_cnt + 1'b1;
         if (w_drop_evt) r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

   assign stat_echo_count = r_echo_cnt;
   assign stat_drop_count = r_drop_cnt;
`endif

endmodule

`default_nettype wire
